// File: rtl/fft_peak_detector.sv
// Per-frame peak search over |X[k]|^2 of an FFT source stream (3-stage pipeline + frame FSM).
// Optional malformed-frame detection is enabled with `define FFT_FRAME_CHECK_EN.
module fft_peak_detector #(
    parameter int DATA_W   = 16,
    parameter int N_POINTS = 8192,
    parameter int IDX_W    = 13,
    parameter int MIN_BIN  = 1,
    parameter int MAX_BIN  = 4095
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [DATA_W-1:0]   source_real,
    input  logic signed [DATA_W-1:0]   source_imag,
    input  logic                       source_valid,
    input  logic                       source_sop,
    input  logic                       source_eop,
    output logic                       source_ready,
    output logic [IDX_W-1:0]           peak_bin,
    output logic [2*DATA_W-1:0]        peak_mag,
    output logic                       peak_valid,
    output logic                       frame_err
);
    localparam int PROD_W = 2*DATA_W - 1;
    localparam int PWR_W  = 2*DATA_W;
    localparam logic [IDX_W-1:0] MIN_IDX  = IDX_W'(MIN_BIN);
    localparam logic [IDX_W-1:0] MAX_IDX  = IDX_W'(MAX_BIN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

    // The bin counter wraps at IDX_W bits, so the frame length must match it exactly.
    if (N_POINTS != (1 << IDX_W)) begin : g_bad_idx_w
        $error("N_POINTS must equal 2**IDX_W");
    end

    typedef enum logic [1:0] {IDLE, FRAME, FLUSH} state_t;

    function automatic logic [PROD_W-1:0] square(input logic signed [DATA_W-1:0] x);
        logic signed [PWR_W-1:0] p;
        p = PWR_W'(x) * PWR_W'(x);
        return PROD_W'(p);
    endfunction

    function automatic logic in_range(input logic [IDX_W-1:0] i);
        return (i >= MIN_IDX) && (i <= MAX_IDX);
    endfunction

    state_t             state, state_next;
    logic [1:0]         flush_cnt;
    logic [IDX_W-1:0]   idx, idx_cur;
    logic               accept, beat_take, frame_done, err_next;

    assign accept    = source_valid & source_ready;
    assign idx_cur   = source_sop ? '0 : idx + 1'b1;
    assign beat_take = accept && (state == FRAME || source_sop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            flush_cnt <= '0;
            idx       <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= (state == FLUSH) ? flush_cnt + 2'd1 : 2'd0;
            if (beat_take)
                idx <= idx_cur;
        end
    end

    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE:    if (accept && source_sop) state_next = source_eop ? FLUSH : FRAME;
            FRAME:   if (accept && source_eop) state_next = FLUSH;
            FLUSH:   if (flush_cnt == 2'd2) begin
                         state_next = IDLE;
                         frame_done = 1'b1;
                     end
            default: state_next = IDLE;
        endcase
`ifdef FFT_FRAME_CHECK_EN
        if (beat_take) begin
            if (state == FRAME && source_sop)
                err_next = 1'b1;
            if (source_eop != (idx_cur == LAST_IDX)) begin
                err_next   = 1'b1;
                state_next = IDLE;
            end
        end
`endif
    end

    // Ready drops only while draining the pipeline and while reset is held.
    always_comb begin
        source_ready = !reset && (state != FLUSH);
    end

    // Stage p0: register the accepted beat
    logic signed [DATA_W-1:0] re_p0, im_p0;
    logic [IDX_W-1:0]         idx_p0;
    logic                     sop_p0, vld_p0;

    always_ff @(posedge clk) begin
        if (reset) vld_p0 <= 1'b0;
        else       vld_p0 <= beat_take;
        re_p0  <= source_real;
        im_p0  <= source_imag;
        idx_p0 <= idx_cur;
        sop_p0 <= source_sop;
    end

    // Stage p1: squares of both components
    logic [PROD_W-1:0] sq_re_p1, sq_im_p1;
    logic [IDX_W-1:0]  idx_p1;
    logic              sop_p1, vld_p1;

    always_ff @(posedge clk) begin
        if (reset) vld_p1 <= 1'b0;
        else       vld_p1 <= vld_p0;
        sq_re_p1 <= square(re_p0);
        sq_im_p1 <= square(im_p0);
        idx_p1   <= idx_p0;
        sop_p1   <= sop_p0;
    end

    // Stage p2: power sum and running max; a sop beat reaching here restarts the search
    logic [PWR_W-1:0]  pwr, base_mag, max_mag, nxt_mag;
    logic [IDX_W-1:0]  base_bin, max_bin, nxt_bin;

    always_comb begin
        pwr      = PWR_W'(sq_re_p1) + PWR_W'(sq_im_p1);
        base_mag = sop_p1 ? '0 : max_mag;
        base_bin = sop_p1 ? MIN_IDX : max_bin;
        nxt_mag  = base_mag;
        nxt_bin  = base_bin;
        if (in_range(idx_p1) && pwr > base_mag) begin
            nxt_mag = pwr;
            nxt_bin = idx_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p1) begin
            max_mag <= nxt_mag;
            max_bin <= nxt_bin;
        end
    end

    // Result register: published once the flush has drained the last beat
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_bin   <= '0;
            peak_mag   <= '0;
            peak_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            peak_valid <= frame_done;
            frame_err  <= err_next;
            if (frame_done) begin
                peak_bin <= max_bin;
                peak_mag <= max_mag;
            end
        end
    end
endmodule

// File: tb/tb_fft_peak_detector.sv
// Directed-frame bench for fft_peak_detector with a frame-level reference model and per-cycle compare.
// Compile with +define+FFT_FRAME_CHECK_EN to exercise the malformed-frame checks.
module tb_fft_peak_detector;
    localparam int DATA_W  = 16;
    localparam int N       = 8192;
    localparam int IDX_W   = 13;
    localparam int MIN_BIN = 1;
    localparam int MAX_BIN = 4095;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic signed [DATA_W-1:0] source_real = '0;
    logic signed [DATA_W-1:0] source_imag = '0;
    logic                     source_valid = 1'b0;
    logic                     source_sop = 1'b0;
    logic                     source_eop = 1'b0;
    logic                     source_ready;
    logic [IDX_W-1:0]         peak_bin;
    logic [2*DATA_W-1:0]      peak_mag;
    logic                     peak_valid;
    logic                     frame_err;

    always #5 clk = ~clk;

    fft_peak_detector #(
        .DATA_W(DATA_W), .N_POINTS(N), .IDX_W(IDX_W), .MIN_BIN(MIN_BIN), .MAX_BIN(MAX_BIN)
    ) dut (
        .clk(clk), .reset(reset),
        .source_real(source_real), .source_imag(source_imag),
        .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
        .source_ready(source_ready),
        .peak_bin(peak_bin), .peak_mag(peak_mag), .peak_valid(peak_valid), .frame_err(frame_err)
    );

    typedef struct { longint cyc; int bin; longint mag; } exp_t;

    int      tests = 0;
    int      fails = 0;
    longint  cyc = 0;
    bit      mon_en = 1'b0;
    int      set_re[int];
    int      set_im[int];

    // reference model state
    bit      in_frame = 1'b0;
    int      m_idx = 0;
    longint  pw[int];
    longint  flush_eop = -100;
    exp_t    exp_q[$];
    longint  err_q[$];
    int      held_bin = 0;
    longint  held_mag = 0;
    int      results_seen = 0;
    int      errs_seen = 0;
    bit      e_pv, e_err, ok_len;
    longint  p, best_m;
    int      best_b;

    task automatic chk(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_err(input longint c);
        if (err_q.size() == 0 || err_q[err_q.size()-1] != c)
            err_q.push_back(c);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            chk("source_ready", source_ready, (!reset && !(cyc > flush_eop && cyc <= flush_eop + 3)));
            e_pv = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            chk("peak_valid", peak_valid, e_pv);
            if (e_pv) begin
                held_bin = exp_q[0].bin;
                held_mag = exp_q[0].mag;
                void'(exp_q.pop_front());
                results_seen++;
            end
            chk("peak_bin", peak_bin, held_bin);
            chk("peak_mag", peak_mag, held_mag);
            e_err = (err_q.size() > 0) && (err_q[0] == cyc);
            chk("frame_err", frame_err, e_err);
            if (e_err) begin
                void'(err_q.pop_front());
                errs_seen++;
            end

            if (reset) begin
                in_frame  = 1'b0;
                flush_eop = -100;
                exp_q.delete();
                err_q.delete();
                held_bin  = 0;
                held_mag  = 0;
            end else if (source_valid && source_ready) begin
                if (source_sop) begin
`ifdef FFT_FRAME_CHECK_EN
                    if (in_frame) push_err(cyc + 1);
`endif
                    in_frame = 1'b1;
                    m_idx    = 0;
                    pw.delete();
                end else if (in_frame) begin
                    m_idx = (m_idx + 1) % N;
                end
                if (in_frame) begin
                    p = longint'(source_real) * longint'(source_real)
                      + longint'(source_imag) * longint'(source_imag);
                    if (p != 0) pw[m_idx] = p;
                    ok_len = 1'b1;
`ifdef FFT_FRAME_CHECK_EN
                    ok_len = (m_idx == N - 1);
`endif
                    if (source_eop) begin
                        in_frame = 1'b0;
                        if (ok_len) begin
                            best_m = 0;
                            best_b = MIN_BIN;
                            foreach (pw[k])
                                if (k >= MIN_BIN && k <= MAX_BIN && pw[k] > best_m) begin
                                    best_m = pw[k];
                                    best_b = k;
                                end
                            exp_q.push_back('{cyc: cyc + 4, bin: best_b, mag: best_m});
                            flush_eop = cyc;
                        end else begin
                            push_err(cyc + 1);
                        end
                    end else if (!ok_len && m_idx == N - 1) begin
                        in_frame = 1'b0;
                        push_err(cyc + 1);
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int n, input bit with_eop, input int gap_pct, input int reset_at);
        for (int k = 0; k < n; k++) begin
            while (gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct) begin
                source_valid = 1'b0;
                source_sop   = 1'b1;
                source_eop   = 1'b1;
                source_real  = 16'sh7fff;
                source_imag  = 16'sh7fff;
                tick();
            end
            source_real  = set_re.exists(k) ? 16'(set_re[k]) : 16'sd0;
            source_imag  = set_im.exists(k) ? 16'(set_im[k]) : 16'sd0;
            source_sop   = (k == 0);
            source_eop   = with_eop && (k == n - 1);
            source_valid = 1'b1;
            if (k == reset_at) begin
                reset = 1'b1;
                tick();
                tick();
                reset        = 1'b0;
                source_valid = 1'b0;
                source_sop   = 1'b0;
                source_eop   = 1'b0;
                return;
            end
            tick();
        end
        source_valid = 1'b0;
        source_sop   = 1'b0;
        source_eop   = 1'b0;
    endtask

    task automatic wait_result(input string name, input int bin, input longint mag);
        int start;
        start = results_seen;
        for (int t = 0; t < 30 && results_seen == start; t++) tick();
        chk({name, "_result_count"}, results_seen - start, 1);
        chk({name, "_bin"}, peak_bin, bin);
        chk({name, "_mag"}, peak_mag, mag);
        repeat (2) tick();
    endtask

    task automatic wait_none(input string name);
        int start;
        start = results_seen;
        repeat (12) tick();
        chk({name, "_no_result"}, results_seen - start, 0);
    endtask

    task automatic wait_err(input string name);
        int start;
        start = errs_seen;
        for (int t = 0; t < 10 && errs_seen == start; t++) tick();
        chk({name, "_frame_err"}, errs_seen - start, 1);
    endtask

    task automatic clear_table;
        set_re.delete();
        set_im.delete();
    endtask

    initial begin
        @(posedge clk);
        mon_en = 1'b1;
        tick();
        chk("reset_ready", source_ready, 0);
        chk("reset_peak_valid", peak_valid, 0);
        chk("reset_peak_bin", peak_bin, 0);
        chk("reset_peak_mag", peak_mag, 0);
        chk("reset_frame_err", frame_err, 0);
        reset = 1'b0;
        tick();

        // single tone at bin 100
        clear_table();
        set_re[100] = 300; set_im[100] = 400;
        send_frame(N, 1'b1, 0, -1);
        wait_result("tone", 100, 250000);

        // equal power at 50 and 900: lowest index wins
        clear_table();
        set_re[50] = 1000; set_re[900] = 1000;
        send_frame(N, 1'b1, 0, -1);
        wait_result("tie", 50, 1000000);

        // strong bins outside the search range are ignored
        clear_table();
        set_re[0] = 32767;
        set_re[5000] = -32768; set_im[5000] = -32768;
        set_re[7] = 3; set_im[7] = 4;
        send_frame(N, 1'b1, 0, -1);
        wait_result("range", 7, 25);

        // full-scale negative on both components
        clear_table();
        set_re[10] = -32768; set_im[10] = -32768;
        set_re[20] = 32767;  set_im[20] = 32767;
        send_frame(N, 1'b1, 0, -1);
        wait_result("fullscale", 10, 64'd2147483648);

        // gapped frame aborted by reset, then a clean gapped frame
        clear_table();
        set_re[2000] = 20000; set_im[2000] = 20000;
        send_frame(N, 1'b1, 50, 3000);
        wait_none("aborted");
        clear_table();
        set_re[3000] = -100; set_im[3000] = 200;
        set_re[4095] = 200;  set_im[4095] = -100;
        set_re[4096] = 30000;
        send_frame(N, 1'b1, 50, -1);
        wait_result("gapped", 3000, 50000);

        // short frame: eop at bin 4000
        clear_table();
        set_re[3999] = 7;
        send_frame(4001, 1'b1, 0, -1);
`ifdef FFT_FRAME_CHECK_EN
        wait_err("short");
        wait_none("short");
`else
        wait_result("short", 3999, 49);
`endif

        // partial frame interrupted by a new sop at bin 200
        clear_table();
        set_re[150] = 1000; set_im[150] = 1000;
        send_frame(200, 1'b0, 0, -1);
        clear_table();
        set_re[151] = 10; set_im[151] = 10;
        send_frame(N, 1'b1, 0, -1);
`ifdef FFT_FRAME_CHECK_EN
        chk("restart_err_seen", errs_seen, 2);
`endif
        wait_result("restart", 151, 200);

        // single-beat frame (sop and eop together)
        clear_table();
        set_re[0] = 5; set_im[0] = 5;
        send_frame(1, 1'b1, 0, -1);
`ifdef FFT_FRAME_CHECK_EN
        wait_err("one_bin");
        wait_none("one_bin");
`else
        wait_result("one_bin", MIN_BIN, 0);
`endif

        repeat (10) tick();
        chk("pending_results", exp_q.size(), 0);
        chk("pending_errs", err_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
